// File: rtl/trivium_stream_cipher_w.sv
// Trivium keystream core producing WORD_W keystream bits per clock, XORed onto a
// valid/ready word stream with a single registered output stage and a per-key word budget.
module trivium_stream_cipher_w #(
    parameter int WORD_W      = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int MAX_WORDS   = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [79:0]       key,
    input  logic [79:0]       iv,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              expired
);

    localparam int INIT_CYCLES = INIT_ROUNDS / WORD_W;
    localparam int ICW         = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WCW         = $clog2(MAX_WORDS + 1);
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
    localparam logic [WCW-1:0] WORD_MAX  = WCW'(MAX_WORDS);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_RUN,
        S_EXPIRED
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [287:0]      st;
    logic [287:0]      st_load;
    logic [287:0]      st_adv;
    logic [287:0]      s;
    logic              t1;
    logic              t2;
    logic              t3;
    logic [WORD_W-1:0] z_word;
    logic [ICW-1:0]    init_cnt;
    logic [WCW-1:0]    word_cnt;
    logic              xfer;

    // st[i-1] holds Trivium state bit s(i).
    always_comb begin
        st_load          = '0;
        st_load[79:0]    = key;
        st_load[172:93]  = iv;
        st_load[287:285] = 3'b111;
    end

    // WORD_W rounds unrolled; bit j of z_word comes from round j.
    always_comb begin
        s      = st;
        z_word = '0;
        t1     = 1'b0;
        t2     = 1'b0;
        t3     = 1'b0;
        for (int j = 0; j < WORD_W; j++) begin
            t1        = s[65] ^ s[92];
            t2        = s[161] ^ s[176];
            t3        = s[242] ^ s[287];
            z_word[j] = t1 ^ t2 ^ t3;
            t1        = t1 ^ (s[90] & s[91]) ^ s[170];
            t2        = t2 ^ (s[174] & s[175]) ^ s[263];
            t3        = t3 ^ (s[285] & s[286]) ^ s[68];
            s         = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        st_adv = s;
    end

    // start masks in_ready so an aborting cycle never looks like an accepted word upstream.
    assign in_ready = (state == S_RUN) && !start && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == S_LOAD) || (state == S_INIT);
    assign expired  = (state == S_EXPIRED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_IDLE:    state_next = S_IDLE;
                S_LOAD:    state_next = S_INIT;
                S_INIT:    if (init_cnt == INIT_LAST) state_next = S_RUN;
                S_RUN:     if (xfer && (word_cnt == WORD_LAST)) state_next = S_EXPIRED;
                S_EXPIRED: state_next = S_EXPIRED;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            init_cnt  <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (start) begin
            st        <= st_load;
            init_cnt  <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == S_INIT) begin
                st       <= st_adv;
                init_cnt <= init_cnt + 1'b1;
            end else if (xfer) begin
                st <= st_adv;
            end
            if (xfer) begin
                out_data  <= in_data ^ z_word;
                out_valid <= 1'b1;
                if (word_cnt != WORD_MAX) word_cnt <= word_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_cipher_w.sv
// Bench for trivium_stream_cipher_w: a WORD_W=8 and a WORD_W=1 instance checked against a
// bit-serial Trivium reference, covering latency, backpressure, budget expiry, reset and abort.
module tb_trivium_stream_cipher_w;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [79:0] key;
    logic [79:0] iv;

    logic       start8, in_valid8, in_ready8, out_valid8, out_ready8, busy8, expired8;
    logic [7:0] in_data8, out_data8;
    logic       start1, in_valid1, in_ready1, out_valid1, out_ready1, busy1, expired1;
    logic [0:0] in_data1, out_data1;

    trivium_stream_cipher_w #(.WORD_W(8), .INIT_ROUNDS(1152), .MAX_WORDS(300)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .key(key), .iv(iv),
        .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready8),
        .busy(busy8), .expired(expired8)
    );

    trivium_stream_cipher_w #(.WORD_W(1), .INIT_ROUNDS(1152), .MAX_WORDS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .key(key), .iv(iv),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .busy(busy1), .expired(expired1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bit-serial reference model (s1..s288) ----------------
    logic [1:288] ms;

    task automatic model_round(output logic z);
        logic a1, a2, a3;
        a1 = ms[66] ^ ms[93];
        a2 = ms[162] ^ ms[177];
        a3 = ms[243] ^ ms[288];
        z  = a1 ^ a2 ^ a3;
        a1 = a1 ^ (ms[91] & ms[92]) ^ ms[171];
        a2 = a2 ^ (ms[175] & ms[176]) ^ ms[264];
        a3 = a3 ^ (ms[286] & ms[287]) ^ ms[69];
        ms[1:93]    = {a3, ms[1:92]};
        ms[94:177]  = {a1, ms[94:176]};
        ms[178:288] = {a2, ms[178:287]};
    endtask

    task automatic model_load(input logic [79:0] k, input logic [79:0] v);
        logic z;
        ms = '0;
        for (int i = 0; i < 80; i++) begin
            ms[i + 1]  = k[i];
            ms[i + 94] = v[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int r = 0; r < 1152; r++) model_round(z);
    endtask

    task automatic model_word(output logic [7:0] w);
        logic b;
        for (int j = 0; j < 8; j++) begin
            model_round(b);
            w[j] = b;
        end
    endtask

    // ---------------- scoreboard for the 8-bit instance ----------------
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] sb_w;
    bit         sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (out_valid8 && out_ready8) begin
                if (exp_q.size() == 0) check("sb_unexpected_word", 64'(out_data8), 64'hx);
                else check("sb_word", 64'(out_data8), 64'(exp_q.pop_front()));
                cap_q.push_back(out_data8);
            end
            if (in_valid8 && in_ready8) begin
                model_word(sb_w);
                exp_q.push_back(in_data8 ^ sb_w);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] pt_arr[256];
    logic [7:0] ct_arr[256];

    task automatic pulse_start8();
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
    endtask

    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    // Cycles counted from the start cycle until in_ready is first seen high.
    task automatic wait_ready8(input int budget, output int cyc);
        cyc = 1;
        while (!in_ready8 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready8) check("ready8_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_ready1(input int budget, output int cyc);
        cyc = 1;
        while (!in_ready1 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready1) check("ready1_timeout", 64'd0, 64'd1);
    endtask

    // mode 0: zero words, 1: random plaintext into pt_arr, 2: words from ct_arr
    task automatic stream8(input int n, input int mode);
        bit acc;
        out_ready8 = 1'b1;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       in_data8 = 8'h00;
                1: begin
                    in_data8  = 8'($urandom_range(0, 255));
                    pt_arr[k] = in_data8;
                end
                default: in_data8 = ct_arr[k];
            endcase
            in_valid8 = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 50 && !acc; c++) begin
                acc = in_ready8;
                @(posedge clk); #1;
            end
            if (!acc) check("accept_timeout", 64'd0, 64'd1);
        end
        in_valid8 = 1'b0;
    endtask

    task automatic drain8();
        out_ready8 = 1'b1;
        in_valid8  = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero8(input string tag);
        check({tag, "_in_ready"},  64'(in_ready8),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid8), 64'd0);
        check({tag, "_out_data"},  64'(out_data8),  64'd0);
        check({tag, "_busy"},      64'(busy8),      64'd0);
        check({tag, "_expired"},   64'(expired8),   64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   cyc;
        logic zb;
        rst = 1'b1;
        start8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        key = 80'h0123_4567_89ab_cdef_0f1e;
        iv  = 80'hfedc_ba98_7654_3210_a5c3;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero8("reset8");
        check("reset1_out_valid", 64'(out_valid1), 64'd0);
        check("reset1_busy",      64'(busy1),      64'd0);
        rst = 1'b0;

        // WORD_W=1: latency, keystream bits, budget expiry and rekey
        pulse_start1();
        check("w1_busy_after_start", 64'(busy1), 64'd1);
        wait_ready1(1300, cyc);
        check("w1_start_to_ready", 64'(cyc), 64'd1154);
        model_load(key, iv);
        in_valid1 = 1'b1;
        in_data1  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            model_round(zb);
            check("w1_out_valid", 64'(out_valid1), 64'd1);
            check("w1_ks_bit", 64'(out_data1), 64'(zb));
        end
        check("w1_expired", 64'(expired1), 64'd1);
        check("w1_expired_in_ready", 64'(in_ready1), 64'd0);
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        check("w1_drained", 64'(out_valid1), 64'd0);
        pulse_start1();
        check("w1_rekey_busy", 64'(busy1), 64'd1);
        check("w1_rekey_expired", 64'(expired1), 64'd0);

        // WORD_W=8: latency and zero-input keystream
        sb_en = 1'b1;
        model_load(key, iv);
        pulse_start8();
        check("w8_busy_after_start", 64'(busy8), 64'd1);
        wait_ready8(400, cyc);
        check("w8_start_to_ready", 64'(cyc), 64'd146);
        stream8(32, 0);
        drain8();

        // encrypt 256 words then decrypt with the same key/iv
        model_load(key, iv);
        pulse_start8();
        wait_ready8(400, cyc);
        cap_q.delete();
        stream8(256, 1);
        drain8();
        check("ct_count", 64'(cap_q.size()), 64'd256);
        for (int i = 0; i < 256; i++) ct_arr[i] = (i < cap_q.size()) ? cap_q[i] : 8'h00;
        model_load(key, iv);
        pulse_start8();
        wait_ready8(400, cyc);
        cap_q.delete();
        stream8(256, 2);
        drain8();
        check("pt_count", 64'(cap_q.size()), 64'd256);
        for (int i = 0; i < 256 && i < cap_q.size(); i++) check("pt_restored", 64'(cap_q[i]), 64'(pt_arr[i]));

        // output backpressure for 5 cycles
        model_load(key, iv);
        pulse_start8();
        wait_ready8(400, cyc);
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_data8   = 8'h5a;
        @(posedge clk); #1;
        check("bp_out_valid", 64'(out_valid8), 64'd1);
        check("bp_pending", 64'(exp_q.size()), 64'd1);
        in_data8 = 8'ha5;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 64'(in_ready8), 64'd0);
            if (exp_q.size() > 0) check("bp_hold", 64'(out_data8), 64'(exp_q[0]));
            @(posedge clk); #1;
        end
        stream8(6, 0);
        drain8();

        // start together with an offered word in RUN
        in_valid8  = 1'b1;
        in_data8   = 8'h33;
        out_ready8 = 1'b1;
        start8     = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready8), 64'd0);
        @(posedge clk); #1;
        start8    = 1'b0;
        in_valid8 = 1'b0;
        check("abort_out_valid", 64'(out_valid8), 64'd0);
        check("abort_busy", 64'(busy8), 64'd1);
        check("abort_no_accept", 64'(exp_q.size()), 64'd0);

        // reset during INIT
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero8("rst_init");
        rst = 1'b0;

        // reset during RUN with a pending word
        model_load(key, iv);
        pulse_start8();
        wait_ready8(400, cyc);
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_data8   = 8'h00;
        @(posedge clk); #1;
        check("rst_run_pending", 64'(out_valid8), 64'd1);
        in_valid8 = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_all_zero8("rst_run");
        rst = 1'b0;
        out_ready8 = 1'b1;

        // fresh start after reset reproduces the reference keystream
        model_load(key, iv);
        pulse_start8();
        wait_ready8(400, cyc);
        check("post_rst_start_to_ready", 64'(cyc), 64'd146);
        stream8(8, 0);
        drain8();

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
